// File: rtl/bloco_operativo.sv
// Datapath with three W-bit registers (RX, RH, RS), an add/multiply ALU and a
// shared write bus; zero and estouro flags track ALU results written back.
module bloco_operativo #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] entrada,
  input  logic [1:0]   M0,
  input  logic [1:0]   M1,
  input  logic [1:0]   M2,
  input  logic         LX,
  input  logic         LH,
  input  logic         LS,
  input  logic         H,
  output logic [W-1:0] saida,
  output logic         zero,
  output logic         estouro
);

  localparam int unsigned PW = 2 * W;

  logic [W-1:0]  rx;
  logic [W-1:0]  rh;
  logic [W-1:0]  rs;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W:0]    sum;
  logic [PW-1:0] prod;
  logic [W-1:0]  alu_res;
  logic          alu_ovf;
  logic [W-1:0]  wbus;
  logic          any_load;
  logic          alu_write;

  // Operand A select
  always_comb begin
    op_a = entrada;
    unique case (M0)
      2'b00: op_a = entrada;
      2'b01: op_a = rx;
      2'b10: op_a = rh;
      2'b11: op_a = rs;
      default: op_a = entrada;
    endcase
  end

  // Operand B select; code 11 feeds the constant 1 for increments
  always_comb begin
    op_b = rx;
    unique case (M1)
      2'b00: op_b = rx;
      2'b01: op_b = rh;
      2'b10: op_b = rs;
      2'b11: op_b = W'(1);
      default: op_b = rx;
    endcase
  end

  // ALU: full-width results kept so overflow can be detected
  always_comb begin
    sum     = (W+1)'(op_a) + (W+1)'(op_b);
    prod    = PW'(op_a) * PW'(op_b);
    alu_res = H ? prod[W-1:0] : sum[W-1:0];
    alu_ovf = H ? (|prod[PW-1:W]) : sum[W];
  end

  // Write-bus select
  always_comb begin
    wbus = alu_res;
    unique case (M2)
      2'b00: wbus = alu_res;
      2'b01: wbus = entrada;
      2'b10: wbus = '0;
      2'b11: wbus = op_a;
      default: wbus = alu_res;
    endcase
  end

  assign any_load  = LX | LH | LS;
  assign alu_write = any_load && (M2 == 2'b00);

  // Register file; all operands above use pre-edge values
  always_ff @(posedge clk) begin
    if (rst) begin
      rx <= '0;
      rh <= '0;
      rs <= '0;
    end else begin
      if (LX) rx <= wbus;
      if (LH) rh <= wbus;
      if (LS) rs <= wbus;
    end
  end

  // Flags only react to ALU results actually written somewhere
  always_ff @(posedge clk) begin
    if (rst) begin
      zero    <= 1'b1;
      estouro <= 1'b0;
    end else if (alu_write) begin
      zero <= (alu_res == '0);
      if (alu_ovf) estouro <= 1'b1;
    end
  end

  assign saida = rs;

endmodule

// File: tb/tb_bloco_operativo.sv
// Bench for bloco_operativo: directed vector table plus random stimulus
// checked against an arithmetic reference model.
module tb_bloco_operativo;

  localparam int unsigned W = 16;
  localparam longint unsigned MODW = 64'd1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] entrada;
  logic [1:0]   M0, M1, M2;
  logic         LX, LH, LS, H;
  logic [W-1:0] saida;
  logic         zero, estouro;

  bloco_operativo #(.W(W)) dut (
    .clk(clk), .rst(rst), .entrada(entrada),
    .M0(M0), .M1(M1), .M2(M2),
    .LX(LX), .LH(LH), .LS(LS), .H(H),
    .saida(saida), .zero(zero), .estouro(estouro)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [W-1:0] entrada;
    logic [1:0]   m0, m1, m2;
    logic         lx, lh, ls, h;
    logic [W-1:0] exp_rs, exp_rx, exp_rh;
    logic         exp_zero, exp_estouro;
  } vec_t;

  vec_t tbl[$];
  int   applied = 0;
  int   miscompares = 0;

  // Reference state
  longint unsigned mx, mh, ms;
  logic mz, me;

  function automatic vec_t mk(logic r, logic [W-1:0] e, logic [1:0] a, logic [1:0] b,
                              logic [1:0] c, logic x, logic hh, logic s, logic op,
                              logic [W-1:0] ers, logic [W-1:0] erx, logic [W-1:0] erh,
                              logic ez, logic eo);
    vec_t v;
    v.rst = r; v.entrada = e; v.m0 = a; v.m1 = b; v.m2 = c;
    v.lx = x; v.lh = hh; v.ls = s; v.h = op;
    v.exp_rs = ers; v.exp_rx = erx; v.exp_rh = erh;
    v.exp_zero = ez; v.exp_estouro = eo;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; entrada = v.entrada; M0 = v.m0; M1 = v.m1; M2 = v.m2;
    LX = v.lx; LH = v.lh; LS = v.ls; H = v.h;
  endtask

  task automatic check(input string name, input vec_t v);
    applied++;
    if (saida !== v.exp_rs || dut.rx !== v.exp_rx || dut.rh !== v.exp_rh ||
        zero !== v.exp_zero || estouro !== v.exp_estouro) begin
      miscompares++;
      $display("FAIL %s: got rs=%h rx=%h rh=%h zero=%b estouro=%b, expected rs=%h rx=%h rh=%h zero=%b estouro=%b",
               name, saida, dut.rx, dut.rh, zero, estouro,
               v.exp_rs, v.exp_rx, v.exp_rh, v.exp_zero, v.exp_estouro);
    end
  endtask

  // One clock edge of the reference model, from the behavioural rules
  task automatic model_step(input vec_t v);
    longint unsigned a, b, res, full, bus;
    logic ovf, any;
    if (v.rst) begin
      mx = 0; mh = 0; ms = 0; mz = 1'b1; me = 1'b0;
      return;
    end
    case (v.m0)
      2'd0: a = v.entrada;
      2'd1: a = mx;
      2'd2: a = mh;
      default: a = ms;
    endcase
    case (v.m1)
      2'd0: b = mx;
      2'd1: b = mh;
      2'd2: b = ms;
      default: b = 1;
    endcase
    full = v.h ? a * b : a + b;
    res  = full % MODW;
    ovf  = (full >= MODW);
    case (v.m2)
      2'd0: bus = res;
      2'd1: bus = v.entrada;
      2'd2: bus = 0;
      default: bus = a;
    endcase
    any = v.lx | v.lh | v.ls;
    if (v.lx) mx = bus;
    if (v.lh) mh = bus;
    if (v.ls) ms = bus;
    if (any && v.m2 == 2'd0) begin
      mz = (res == 0);
      if (ovf) me = 1'b1;
    end
  endtask

  initial begin
    vec_t v;
    // rst, entrada, M0, M1, M2, LX, LH, LS, H, exp RS, RX, RH, zero, estouro
    tbl.push_back(mk(1, 16'h1234, 0, 0, 1, 1, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 16'h0005, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0005, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 3, 0, 0, 0, 0, 1, 0, 16'h0005, 16'h0005, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 3, 0, 0, 0, 0, 1, 0, 16'h000A, 16'h0005, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 3, 0, 0, 0, 0, 1, 0, 16'h000F, 16'h0005, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 16'hABCD, 0, 0, 1, 1, 1, 1, 0, 16'hABCD, 16'hABCD, 16'hABCD, 0, 0));
    tbl.push_back(mk(0, 16'h0100, 0, 0, 1, 1, 1, 0, 0, 16'hABCD, 16'h0100, 16'h0100, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 0, 0, 1, 1, 16'h0000, 16'h0100, 16'h0100, 1, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 16'h0F0F, 2'(i), 2'(i + 1), 0, 0, 0, 0, i[0], 16'h0000, 16'h0100, 16'h0100, 1, 1));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 16'hFFFF, 0, 0, 1, 0, 0, 1, 0, 16'hFFFF, 16'h0000, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 3, 3, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1));
    tbl.push_back(mk(1, 16'h0007, 0, 0, 1, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 16'h0007, 0, 0, 1, 0, 0, 1, 0, 16'h0007, 16'h0000, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 16'h0007, 0, 0, 1, 1, 0, 0, 0, 16'h0007, 16'h0007, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 16'h1111, 0, 0, 2, 1, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0));
    tbl.push_back(mk(0, 16'h0009, 0, 0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0009, 1, 0));
    tbl.push_back(mk(0, 16'h2222, 2, 0, 3, 0, 0, 1, 0, 16'h0009, 16'h0000, 16'h0009, 1, 0));
    tbl.push_back(mk(0, 16'h0003, 0, 1, 0, 1, 0, 0, 0, 16'h0009, 16'h000C, 16'h0009, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 2, 0, 0, 1, 0, 1, 16'h0009, 16'h000C, 16'h006C, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check($sformatf("table[%0d]", i), tbl[i]);
    end

    // Random phase; starts with a reset so the model is aligned
    for (int i = 0; i < 400; i++) begin
      v.rst = (i == 0) || ($urandom_range(0, 39) == 0);
      v.entrada = W'($urandom);
      if ($urandom_range(0, 3) == 0) v.entrada = W'($urandom_range(0, 3));
      v.m0 = 2'($urandom); v.m1 = 2'($urandom); v.m2 = 2'($urandom);
      v.lx = 1'($urandom); v.lh = 1'($urandom); v.ls = 1'($urandom);
      v.h  = 1'($urandom);
      drive(v);
      model_step(v);
      v.exp_rs = W'(ms); v.exp_rx = W'(mx); v.exp_rh = W'(mh);
      v.exp_zero = mz; v.exp_estouro = me;
      @(posedge clk);
      #1;
      check($sformatf("random[%0d]", i), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/bloco_operativo.md
BLOCO_OPERATIVO -- requirements
Module: bloco_operativo

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the data width of all registers, buses and ALU operands.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port entrada, input, W bits: external operand, sampled only through the M0 and M2 paths.
REQ-005 The block SHALL have port M0, input, 2 bits: operand-A select.
REQ-006 The block SHALL have port M1, input, 2 bits: operand-B select.
REQ-007 The block SHALL have port M2, input, 2 bits: write-bus select.
REQ-008 The block SHALL have ports LX, LH and LS, input, 1 bit each: load enables for registers RX, RH and RS.
REQ-009 The block SHALL have port H, input, 1 bit: ALU operation select, 0 = add, 1 = multiply.
REQ-010 The block SHALL have port saida, output, W bits: the current RS value.
REQ-011 The block SHALL have port zero, output, 1 bit: registered flag, 1 when the last ALU-sourced write-bus value loaded into any register was 0.
REQ-012 The block SHALL have port estouro, output, 1 bit: sticky overflow flag.

Function
REQ-013 The block SHALL hold three W-bit registers RX, RH and RS; each changes only on a clk rising edge.
REQ-014 Operand A SHALL be selected by M0 as follows: 00 = entrada, 01 = RX, 10 = RH, 11 = RS.
REQ-015 Operand B SHALL be selected by M1 as follows: 00 = RX, 01 = RH, 10 = RS, 11 = constant 1.
REQ-016 The ALU SHALL produce a (W+1)-bit sum A+B when H=0, and the 2W-bit product A*B when H=1; the result is the low W bits.
REQ-017 The write bus SHALL be selected by M2 as follows: 00 = ALU result, 01 = entrada, 10 = 0, 11 = operand A (register move).
REQ-018 When LX, LH or LS is 1 at a rising edge, the corresponding register SHALL load the write bus; otherwise it holds its value.
REQ-019 Simultaneous loads SHALL be allowed: every enabled register loads the same write-bus value in the same edge.
REQ-020 Operands SHALL always use pre-edge register values, so a register may be both source and destination in one cycle (e.g. RS <= RS + RX).
REQ-021 The path from write bus to register SHALL have exactly 1-cycle latency; saida reflects RS with no extra pipeline stage.
REQ-022 zero SHALL update only on edges where M2=00 and at least one load enable is 1, taking the value (ALU result == 0); otherwise it holds.
REQ-023 estouro SHALL be set on an edge where M2=00, at least one load enable is 1, and either: H=0 with the sum carry-out (bit W) = 1, or H=1 with product bits [2W-1:W] nonzero.
REQ-024 Once set, estouro SHALL remain 1 until rst; wrap-around results are still loaded (modulo 2^W).
REQ-025 With all load enables at 0, the block SHALL change no state regardless of M0, M1, M2, H and entrada.
REQ-026 The block SHALL decode all select encodings; there are no illegal codes.

Reset
REQ-027 When rst=1 at a rising edge, RX, RH and RS SHALL become 0, zero SHALL become 1, and estouro SHALL become 0, overriding any load enable in that cycle.
REQ-028 A reset applied mid-sequence SHALL discard all partial results; the first edge after rst falls SHALL behave as from power-up.
REQ-029 Outputs SHALL be defined (0 or 1, no X) from the first edge with rst=1.

Verification
REQ-030 Reset: rst=1 for 1 edge with LX=LH=LS=1 and entrada=0x1234 -> saida=0, RX=RH=0, zero=1, estouro=0.
REQ-031 Load/accumulate: load entrada=5 into RX (M2=01, LX=1), then M0=11, M1=00, H=0, M2=00, LS=1 for 3 edges -> saida=5, 10, 15 on successive edges, with zero=0.
REQ-032 Multiply overflow, W=16: RX=0x0100, RH=0x0100, then M0=01, M1=01, H=1, M2=00, LS=1 -> saida=0x0000, zero=1, estouro=1; then 5 idle edges -> estouro stays 1.
REQ-033 Simultaneous load: M2=01, entrada=0xABCD, LX=LH=LS=1 -> all three registers become 0xABCD on the same edge, and zero/estouro are unchanged.
REQ-034 Self-increment and wrap: RS=0xFFFF, then M0=11, M1=11, H=0, M2=00, LS=1 -> saida=0x0000, zero=1, estouro=1.
REQ-035 Reset mid-operation: assert rst in the same edge as LS=1 with M2=01, entrada=7 -> saida=0, estouro=0; then rst=0 and repeat the load -> saida=7.
